// File: rtl/fm_pkg.sv
// ============================================================================
// fm_pkg : shared types and constants for the frequency-meter control path
// Rev 1.0
// ============================================================================
`default_nettype none

package fm_pkg;

  localparam int CNT_W           = 32;
  localparam int GATE_SHIFT_STEP = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GATE  = 3'd2,
    CLOSE = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Each gate_sel step divides the nominal gate by 4; never return a zero length.
  function automatic logic [CNT_W-1:0] gate_len(input logic [CNT_W-1:0] base,
                                                input logic [1:0]       sel);
    logic [CNT_W-1:0] len;
    len = base >> (GATE_SHIFT_STEP * int'(sel));
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_det.sv
// ============================================================================
// edge_det : one-register rising-edge detector for a synchronized input
// Rev 1.0
// ============================================================================
`default_nettype none

module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

`default_nettype wire

// File: rtl/meas_sequencer.sv
// ============================================================================
// meas_sequencer : builds an fx-edge-aligned gate window from the start command
// Rev 1.0
// ============================================================================
`default_nettype none

module meas_sequencer
  import fm_pkg::*;
#(
  parameter int unsigned GATE_CYC    = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic             fx,
  input  logic [1:0]       gate_sel,
  output logic             gate,
  output logic             busy,
  output logic             done_sig,
  output logic             timeout,
  output logic [CNT_W-1:0] gate_cyc
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  seq_state_t       state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] gcnt_q;
  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] gate_cyc_q;
  logic             gate_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;

  logic             fx_rise;
  logic [CNT_W-1:0] len_d;

  edge_det u_fx_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (fx),
    .rise_o (fx_rise)
  );

  assign len_d = gate_len(CNT_W'(GATE_CYC), gate_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      gcnt_q     <= '0;
      wait_q     <= '0;
      gate_cyc_q <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // The accumulator tracks the registered gate, so it matches the window seen downstream.
      if (gate_q && (gate_cyc_q != CNT_MAX)) begin
        gate_cyc_q <= gate_cyc_q + CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (start_sig) begin
            state_q    <= ARM;
            len_q      <= len_d;
            timeout_q  <= 1'b0;
            wait_q     <= '0;
            gate_cyc_q <= '0;
            busy_q     <= 1'b1;
          end
        end

        ARM: begin
          if (!start_sig) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (fx_rise) begin
            state_q <= GATE;
            gate_q  <= 1'b1;
            gcnt_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end

        GATE: begin
          if (!start_sig) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (gcnt_q == len_q - CNT_W'(1)) begin
            state_q <= CLOSE;
            wait_q  <= '0;
          end else begin
            gcnt_q <= gcnt_q + CNT_W'(1);
          end
        end

        CLOSE: begin
          if (!start_sig) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (fx_rise || (wait_q == WAIT_LAST)) begin
            state_q   <= DONE;
            gate_q    <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= ~fx_rise;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (!start_sig) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          gate_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gate     = gate_q;
  assign busy     = busy_q;
  assign done_sig = done_q;
  assign timeout  = timeout_q;
  assign gate_cyc = gate_cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_meas_sequencer.sv
// ============================================================================
// tb_meas_sequencer : directed self-checking bench for meas_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_meas_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_sig;
  logic        fx;
  logic [1:0]  gate_sel;
  logic        gate;
  logic        busy;
  logic        done_sig;
  logic        timeout;
  logic [31:0] gate_cyc;

  int n_chk;
  int n_err;
  int gate_hi;
  int first_t;
  int done_t;
  int done_cnt;
  logic busy1;

  meas_sequencer #(
    .GATE_CYC    (100),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_sig (start_sig),
    .fx        (fx),
    .gate_sel  (gate_sel),
    .gate      (gate),
    .busy      (busy),
    .done_sig  (done_sig),
    .timeout   (timeout),
    .gate_cyc  (gate_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge (tick 0). fx has period 30, high for phases 5..19,
  // so rising edges are driven at ticks 6, 36, 66, 96, 126, ...
  task automatic run(input logic [1:0] sel, input int fx_stop, input int max_t);
    gate_hi  = 0;
    first_t  = 0;
    done_t   = 0;
    done_cnt = 0;
    busy1    = 1'b0;
    gate_sel  = sel;
    start_sig = 1'b1;
    fx        = 1'b0;
    for (int t = 1; t <= max_t; t++) begin
      @(negedge clk);
      if (t == 1) busy1 = busy;
      if (gate) begin
        gate_hi++;
        if (first_t == 0) first_t = t;
      end
      if (done_sig) begin
        done_cnt++;
        done_t = t;
      end
      if (t == 3) gate_sel = ~sel;
      fx = (t <= fx_stop) && (((t - 1) % 30) >= 5) && (((t - 1) % 30) < 20);
    end
  endtask

  task automatic idle(input int n);
    start_sig = 1'b0;
    fx        = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_sig = 1'b0;
    fx = 1'b0;
    gate_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_gate",     32'(gate),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done_sig), 32'd0);
    check("rst_timeout",  32'(timeout),  32'd0);
    check("rst_gate_cyc", gate_cyc,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal run, length 100: opens after edge at tick 6, closes on edge at tick 126.
    run(2'd0, 1000, 250);
    check("n_busy_next",  32'(busy1),  32'd1);
    check("n_first",      32'(first_t), 32'd7);
    check("n_gate_hi",    32'(gate_hi), 32'd120);
    check("n_gate_cyc",   gate_cyc,     32'd120);
    check("n_done_cnt",   32'(done_cnt), 32'd1);
    check("n_done_t",     32'(done_t),  32'd127);
    check("n_timeout",    32'(timeout), 32'd0);
    check("n_busy_end",   32'(busy),    32'd0);

    // Length 6: closing edge at tick 36.
    idle(3);
    run(2'd2, 1000, 60);
    check("s2_first",    32'(first_t),  32'd7);
    check("s2_gate_hi",  32'(gate_hi),  32'd30);
    check("s2_gate_cyc", gate_cyc,      32'd30);
    check("s2_done_t",   32'(done_t),   32'd37);

    // Length clamps to 1: still closes on the tick-36 edge.
    idle(3);
    run(2'd3, 1000, 60);
    check("s3_gate_hi",  32'(gate_hi),  32'd30);
    check("s3_gate_cyc", gate_cyc,      32'd30);
    check("s3_done_cnt", 32'(done_cnt), 32'd1);

    // No signal: 50 cycles in ARM then DONE.
    idle(3);
    run(2'd0, 0, 80);
    check("ns_gate_hi",  32'(gate_hi),  32'd0);
    check("ns_gate_cyc", gate_cyc,      32'd0);
    check("ns_timeout",  32'(timeout),  32'd1);
    check("ns_done_t",   32'(done_t),   32'd51);
    check("ns_done_cnt", 32'(done_cnt), 32'd1);

    // Lost signal in CLOSE: length 6 then 50 cycles waiting.
    idle(3);
    run(2'd2, 20, 100);
    check("ls_first",    32'(first_t),  32'd7);
    check("ls_gate_hi",  32'(gate_hi),  32'd56);
    check("ls_gate_cyc", gate_cyc,      32'd56);
    check("ls_timeout",  32'(timeout),  32'd1);
    check("ls_done_t",   32'(done_t),   32'd63);

    // Abort mid-GATE at tick 50.
    idle(3);
    run(2'd0, 1000, 50);
    start_sig = 1'b0;
    @(negedge clk);
    check("ab_gate",     32'(gate),     32'd0);
    check("ab_busy",     32'(busy),     32'd0);
    check("ab_done",     32'(done_sig | (done_cnt != 0)), 32'd0);
    check("ab_gate_cyc", gate_cyc,      32'd44);
    check("ab_timeout",  32'(timeout),  32'd0);

    // Clean restart after abort.
    idle(2);
    run(2'd0, 1000, 200);
    check("rs_gate_hi",  32'(gate_hi),  32'd120);
    check("rs_gate_cyc", gate_cyc,      32'd120);
    check("rs_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-gate.
    idle(3);
    run(2'd0, 1000, 30);
    check("pre_rst_cyc", gate_cyc,      32'd23);
    rst_n = 1'b0;
    #1;
    check("ar_gate",     32'(gate),     32'd0);
    check("ar_busy",     32'(busy),     32'd0);
    check("ar_done",     32'(done_sig), 32'd0);
    check("ar_timeout",  32'(timeout),  32'd0);
    check("ar_gate_cyc", gate_cyc,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    run(2'd2, 1000, 60);
    check("ar_run_cyc",  gate_cyc,      32'd30);
    check("ar_run_done", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/meas_sequencer.md
# meas_sequencer

Measurement sequencer for the digital frequency meter. It turns the MCU start command into an equal-precision gate window: the gate opens on a rising edge of the measured signal, stays open for a preset time, and closes on the next rising edge. It reports completion, timeout and the actual gate length. It sits between the synchronized `fx` / `start_sig` inputs and the counting datapath. Its `gate` output drives the counters' enable and the gate LED.

## Interface
Parameters:
- `GATE_CYC`, 50_000_000: nominal gate length in `clk` cycles at `gate_sel` = 0 (1 s at 50 MHz).
- `TIMEOUT_CYC`, 100_000_000: maximum wait for an `fx` rising edge, in the ARM and CLOSE states.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_sig` in 1: MCU start command, level, high = run; already synchronized.
- `fx` in 1: measured signal, already 2-FF synchronized.
- `gate_sel` in 2: gate range. Gate length = `GATE_CYC >> (2*gate_sel)`, clamped to a minimum of 1.
- `gate` out 1: gate window, registered; counter enable and LED.
- `busy` out 1: high in ARM, GATE and CLOSE.
- `done_sig` out 1: one-cycle completion pulse.
- `timeout` out 1: sticky status of the last run. Set when no `fx` edge arrived within `TIMEOUT_CYC`.
- `gate_cyc` out 32: actual gate-open length, in `clk` cycles, of the last run.

## Operation
- `fx` edge detect: `fx_rise` = `fx` & ~`fx_d`, where `fx_d` is `fx` delayed by one register.
- States and transitions:
  - IDLE: on `start_sig`=1, latch the gate length from `gate_sel`, clear `timeout`, clear the wait counter → ARM.
  - ARM: on `fx_rise` → GATE and set `gate`. If the wait counter reaches `TIMEOUT_CYC`-1 → DONE with `timeout`=1; `gate` never opens and `gate_cyc`=0.
  - GATE: the gate counter counts up from 0. When it reaches the latched length - 1 → CLOSE. `fx` edges are ignored in GATE.
  - CLOSE: on `fx_rise`, clear `gate` → DONE. If the wait counter reaches `TIMEOUT_CYC`-1, clear `gate` → DONE with `timeout`=1.
  - DONE: pulse `done_sig` for 1 cycle on entry. Hold in DONE until `start_sig`=0, then → IDLE. There is no retrigger while `start_sig` stays high.
- Abort: `start_sig`=0 in ARM, GATE or CLOSE → IDLE next cycle. `gate` drops, and `done_sig`, `timeout` and `gate_cyc` are unchanged.
- `gate_cyc` increments every cycle while `gate`=1 and is cleared on IDLE→ARM. It saturates at 2^32-1.
- The wait counter is cleared on entry to ARM and on entry to CLOSE.
- A `gate_sel` change after IDLE is ignored until the next run.

## Timing
- Reset values: state IDLE; `gate`, `busy`, `done_sig`, `timeout` = 0; `gate_cyc` = 0.
- `start_sig` high at cycle n → state ARM and `busy`=1 at n+1.
- `fx_rise` sampled at cycle n in ARM → `gate`=1 at n+1.
- Gate open duration in cycles = latched length + (cycles spent in CLOSE until `fx_rise`) + 1. `gate_cyc` equals this exactly.
- `fx_rise` at cycle n in CLOSE → `gate`=0 at n+1, `done_sig`=1 at n+1 only, `busy`=0 at n+1.
- Timeout at cycle n → same timing as the CLOSE edge case.
- `rst_n` low at any time clears all state immediately, asynchronously, including mid-gate.
- `fx_rise` on the same cycle the GATE count expires is not a closing edge; closing requires an edge sampled in CLOSE.

## Structure
- Shared package `fm_pkg`:
  - state enum `seq_state_t` (IDLE, ARM, GATE, CLOSE, DONE);
  - constant `GATE_SHIFT_STEP` = 2;
  - width constant `CNT_W` = 32.
- Sub-module `edge_det`: registers `fx` and produces `fx_rise`. It is reused later for `fxB`.
- Everything else lives in one FSM with a gate counter, a wait counter and a `gate_cyc` accumulator.

## Test plan
- Normal run: `GATE_CYC`=100, `gate_sel`=0, `fx` period 30 cycles, start held high → `gate` high for 100..129 cycles starting 1 cycle after an `fx` edge; one `done_sig` pulse; `gate_cyc` matches the measured high time; `timeout`=0.
- Range: `gate_sel`=2 with `GATE_CYC`=100 → length 6, gate open 6..(6+period) cycles. `gate_sel`=3 → length clamps to 1.
- No signal: `fx` stuck low, `TIMEOUT_CYC`=50 → DONE after 50 cycles in ARM; `done_sig` pulses; `timeout`=1; `gate` never rises; `gate_cyc`=0.
- Lost signal in CLOSE: `fx` stops after the gate opens → `gate` closes after `TIMEOUT_CYC` cycles in CLOSE; `timeout`=1.
- Abort: `start_sig` dropped mid-GATE → `gate`=0 next cycle, no `done_sig`, state IDLE. Restarting gives a clean run.
- Reset mid-gate plus no retrigger: `rst_n` pulsed during GATE → all outputs 0 immediately. Holding start high after DONE produces exactly one `done_sig`.
